fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
Read-side drain engine for async_fifo1. Runs in the FIFO read clock domain and pulls words off the FIFO read port via rd_inc/rd_empty/rd_data. Presents them downstream as a valid/ready stream through a 2-entry skid buffer, so there is no combinational path from m_ready to rd_inc. It also keeps a running count of words delivered.

Parameters:
DATA_SIZE, 8, FIFO word width; must match async_fifo1 DATA_SIZE.
CNT_W, 16, width of the delivered-word counter.

Ports:
rd_clk  input  1  read-domain clock; all state updates on posedge.
rd_rst  input  1  asynchronous, active-high reset.
rd_en  input  1  drain enable; 0 = issue no new FIFO pops.
rd_empty  input  1  FIFO empty flag; registered inside the FIFO.
rd_data  input  DATA_SIZE  FIFO head word; valid whenever rd_empty=0 (first-word fall-through).
rd_inc  output  1  FIFO pop strobe; one word is consumed per cycle it is high.
m_valid  output  1  downstream data valid.
m_data  output  DATA_SIZE  downstream data.
m_ready  input  1  downstream accept.
occ  output  2  skid-buffer occupancy: 0, 1 or 2.
word_cnt  output  CNT_W  words accepted downstream (m_valid&&m_ready) since reset.

Behaviour:
- Reset (async assert, release sync to rd_clk): occ=0, m_valid=0, m_data=0, word_cnt=0, both buffer entries=0. rd_inc=0 while rd_rst=1.
- rd_inc is combinational: rd_inc = rd_en && !rd_empty && (occ!=2) && !rd_rst.
  - It depends only on registered occ, never on m_ready.
- Push: when rd_inc=1, rd_data is captured at that posedge into the tail entry.
- Pop: when m_valid && m_ready at a posedge, the head entry leaves.
- Buffer is strict FIFO order: head = entry0, tail = entry1.
- On a pop, entry1 shifts to entry0.
- FSM on occ:
  - EMPTY(0): push -> ONE.
  - ONE(1): push and no pop -> TWO; pop and no push -> EMPTY; push and pop together -> ONE, new word becomes head.
  - TWO(2): pop -> ONE (no push is possible in TWO); no pop -> hold.
- m_valid = (occ!=0), driven from register state. m_data = entry0.
- m_data is stable while m_valid && !m_ready.
- Latency: a word popped at edge N is presented on m_valid/m_data after edge N (one cycle).
- Throughput: with m_ready held at 1 and the FIFO non-empty, occ stays at 1 and rd_inc is asserted every cycle (one word per cycle).
- Backpressure: after m_ready drops, at most 2 words are held, then rd_inc deasserts. When m_ready returns, rd_inc re-asserts the cycle after occ leaves 2.
- rd_en=0 stops pops only; buffered words still drain downstream.
- rd_empty rising stops pops the same cycle (combinational). No pop is ever issued while rd_empty=1.
- word_cnt increments by 1 per accepted transfer and wraps 2^CNT_W-1 -> 0 silently.
- Reset mid-transfer: buffered data is discarded; FIFO pointers are not affected by this block.

Optional Feature:
RD_PARITY_EN: when defined, adds output m_parity (1 bit) = even parity (XOR reduction) of m_data. Parity is computed at capture and stored alongside each entry, so it is aligned with m_data. It resets to 0. When not defined, the port and storage are absent and the behaviour is otherwise identical.

Test Plan:
- Reset then idle, rd_empty=1 -> rd_inc=0, m_valid=0, occ=0, word_cnt=0 for 20 cycles.
- FIFO preloaded with 0x11,0x22,0x33,0x44, m_ready=1, rd_en=1 -> four consecutive rd_inc cycles; m_data=0x11..0x44 in order on consecutive cycles; word_cnt=4; occ returns to 0.
- Same 4 words, m_ready=0 -> exactly 2 pops, occ=2, m_data holds 0x11. Raise m_ready -> remaining 0x33,0x44 are popped and all 4 words are delivered in order with no loss or duplication.
- rd_en toggled 0 for 3 cycles mid-stream with 6 words queued -> no rd_inc during those cycles; buffered words drain; the stream resumes in order; total word_cnt=6.
- Assert rd_rst with occ=2 -> occ=0, m_valid=0, m_data=0 immediately (asynchronous); after release, the next FIFO word (0x55) is delivered normally.
- CNT_W=4, 17 words streamed -> word_cnt reads 0x1 (wrap). With RD_PARITY_EN defined and data 0x07 -> m_parity=1; data 0x03 -> m_parity=0.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the FIFO read port into a 2-entry valid/ready skid buffer and counts the words delivered.
// Optional macro RD_PARITY_EN adds m_parity, which is stored with each entry so it stays aligned with m_data.
module fifo_rd_stream #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 rd_en,
  input  logic                 rd_empty,
  input  logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_inc,
  output logic                 m_valid,
  output logic [DATA_SIZE-1:0] m_data,
  input  logic                 m_ready,
  output logic [1:0]           occ,
`ifdef RD_PARITY_EN
  output logic                 m_parity,
`endif
  output logic [CNT_W-1:0]     word_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`ifdef RD_PARITY_EN
  localparam int W = DATA_SIZE + 1;
`else
  localparam int W = DATA_SIZE;
`endif
  state_t state, nxt;
  logic [W-1:0] e0, e1, e0_n, e1_n, din;
  logic push, pop;
`ifdef RD_PARITY_EN
  assign din = {^rd_data, rd_data};
  assign m_parity = e0[DATA_SIZE];
`else
  assign din = rd_data;
`endif
  // Pop decision uses only registered occupancy, keeping m_ready off the rd_inc path.
  assign rd_inc = rd_en && !rd_empty && (state != TWO) && !rd_rst;
  assign push = rd_inc;
  assign pop = m_valid && m_ready;
  assign m_valid = state != EMPTY;
  assign m_data = e0[DATA_SIZE-1:0];
  assign occ = state;
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state <= EMPTY;
      e0 <= '0;
      e1 <= '0;
      word_cnt <= '0;
    end else begin
      state <= nxt;
      e0 <= e0_n;
      e1 <= e1_n;
      if (pop) word_cnt <= word_cnt + 1'b1;
    end
  end
  always_comb begin
    nxt = state;
    e0_n = e0;
    e1_n = e1;
    case (state)
      EMPTY: if (push) begin
        nxt = ONE;
        e0_n = din;
      end
      ONE: if (push && !pop) begin
        nxt = TWO;
        e1_n = din;
      end else if (pop && !push) begin
        nxt = EMPTY;
      end else if (push && pop) begin
        e0_n = din;
      end
      TWO: if (pop) begin
        nxt = ONE;
        e0_n = e1;
      end
      default: nxt = EMPTY;
    endcase
  end
endmodule
